// File: rtl/mac_pkg.sv
// Shared types and sizing for the MAC sequencer slice.
// Widths are fixed here so every file agrees on operand, result and length sizes.
package mac_pkg;

    localparam int DATA_W  = 8;
    localparam int ACC_W   = 16;
    localparam int MAX_LEN = 64;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        ACCUM   = 3'd2,
        CAPTURE = 3'd3,
        HOLD    = 3'd4
    } seq_state_t;

endpackage

// File: rtl/mac_sequencer_if.sv
// Bundle of job, pair stream, MAC drive and result signals around the sequencer.
// Valid/ready rule: a transfer happens on a rising edge where valid and ready are both high;
// once valid is raised, it and its payload stay unchanged until that edge.
interface mac_sequencer_if;
    import mac_pkg::*;

    logic              start;
    logic [LEN_W-1:0]  length;
    logic [DATA_W-1:0] bias_in;
    logic              busy;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [DATA_W-1:0] in_weight;

    logic              mac_clear;
    logic              mac_enable;
    logic [DATA_W-1:0] mac_data;
    logic [DATA_W-1:0] mac_weight;
    logic [DATA_W-1:0] mac_bias;
    logic [ACC_W-1:0]  mac_result;

    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_result;

    // Current FSM state, exposed for observation.
    seq_state_t        state;

    modport master (
        input  start, length, bias_in, in_valid, in_data, in_weight, mac_result, out_ready,
        output busy, in_ready, mac_clear, mac_enable, mac_data, mac_weight, mac_bias,
               out_valid, out_result, state
    );

    modport slave (
        output start, length, bias_in, in_valid, in_data, in_weight, mac_result, out_ready,
        input  busy, in_ready, mac_clear, mac_enable, mac_data, mac_weight, mac_bias,
               out_valid, out_result, state
    );

endinterface

// File: rtl/mac_seq_counter.sv
// Loadable down-counter tracking the pairs still owed to the current job.
// Decrementing stops at zero so a stray dec can never wrap to a huge count.
module mac_seq_counter
    import mac_pkg::*;
#(
    parameter int W = LEN_W
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         zero
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign count = cnt_q;
    assign zero  = (cnt_q == '0);

endmodule

// File: rtl/mac_sequencer.sv
// Job controller for one signed 8x8->16 MAC: clears it, streams pairs into it,
// then captures the biased result and holds it until the activation stage takes it.
module mac_sequencer
    import mac_pkg::*;
(
    input  logic             clock,
    input  logic             reset_n,
    mac_sequencer_if.master  bus
);

    seq_state_t        state_q;
    logic [DATA_W-1:0] bias_q;
    logic [ACC_W-1:0]  result_q;
    logic              out_valid_q;

    logic              beat;
    logic              last_beat;
    logic              cnt_load;
    logic [LEN_W-1:0]  cnt;
    logic              cnt_zero;

    assign cnt_load  = (state_q == IDLE) && bus.start;
    assign beat      = (state_q == ACCUM) && bus.in_valid;
    // The beat that consumes the final owed pair closes the accumulation phase.
    assign last_beat = beat && (cnt == LEN_W'(1));

    mac_seq_counter #(.W(LEN_W)) u_counter (
        .clock    (clock),
        .reset_n  (reset_n),
        .load     (cnt_load),
        .dec      (beat),
        .load_val (bus.length),
        .count    (cnt),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            bias_q      <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        bias_q  <= bus.bias_in;
                        state_q <= CLEAR;
                    end
                end
                CLEAR: begin
                    // Length was loaded on the start edge; zero length skips streaming.
                    state_q <= cnt_zero ? CAPTURE : ACCUM;
                end
                ACCUM: begin
                    if (last_beat) begin
                        state_q <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    result_q    <= bus.mac_result;
                    out_valid_q <= 1'b1;
                    state_q     <= HOLD;
                end
                HOLD: begin
                    if (out_valid_q && bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy       = (state_q != IDLE);
    assign bus.in_ready   = (state_q == ACCUM);
    assign bus.mac_clear  = (state_q == CLEAR);
    assign bus.mac_enable = beat;
    assign bus.mac_data   = bus.in_data;
    assign bus.mac_weight = bus.in_weight;
    assign bus.mac_bias   = bias_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = result_q;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_mac_sequencer.sv
// Bench for mac_sequencer: a behavioural MAC in the loop, randomized jobs and a
// dot-product reference model computed with plain integer arithmetic.
module tb_mac_sequencer;
    import mac_pkg::*;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    logic mac_rst;

    mac_sequencer_if bus();

    mac_sequencer dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    // ---------------- behavioural MAC unit ----------------
    logic [ACC_W-1:0] acc;
    assign mac_rst = ~reset_n;

    always @(posedge clock or posedge mac_rst) begin
        if (mac_rst) acc <= '0;
        else if (bus.mac_clear) acc <= '0;
        else if (bus.mac_enable)
            acc <= acc + ($signed({{8{bus.mac_data[7]}}, bus.mac_data}) *
                          $signed({{8{bus.mac_weight[7]}}, bus.mac_weight}));
    end
    assign bus.mac_result = acc + {{8{bus.mac_bias[7]}}, bus.mac_bias};

    // ---------------- bookkeeping ----------------
    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int en_cnt, clr_cnt, rdy_cnt, both_cnt;

    logic [ACC_W-1:0] exp_q[$];
    logic [7:0]       da[$];
    logic [7:0]       wa[$];

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (reset_n) begin
            if (bus.mac_enable) en_cnt++;
            if (bus.mac_clear) clr_cnt++;
            if (bus.in_ready) rdy_cnt++;
            if (bus.mac_clear && bus.mac_enable) both_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic apply_reset();
        reset_n       = 1'b0;
        bus.start     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(posedge clock);
        #1;
    endtask

    // Present one pair and wait for the edge that takes it; ok=0 on timeout.
    task automatic feed_pair(input logic [7:0] d, input logic [7:0] w, output bit ok);
        logic r;
        int   t;
        bus.in_valid  = 1'b1;
        bus.in_data   = d;
        bus.in_weight = w;
        t = 0;
        do begin
            @(negedge clock);
            r = bus.in_ready;
            @(posedge clock);
            #1;
            t++;
        end while (!r && t < 50);
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
        ok = r;
    endtask

    // Run one job using the pairs queued in da/wa.
    task automatic run_job(input int len, input logic [7:0] bias, input int max_bub,
                           input int hold_cyc, input bit poke_start);
        int   s_cyc, v_cyc, t, b, sum, a_i, b_i, stable_bad;
        bit   bubbled, ok;
        logic [ACC_W-1:0] held;

        sum = $signed(bias);
        for (int i = 0; i < len; i++) begin
            a_i = $signed(da[i]);
            b_i = $signed(wa[i]);
            sum += a_i * b_i;
        end
        exp_q.push_back(sum[ACC_W-1:0]);

        en_cnt = 0; clr_cnt = 0; rdy_cnt = 0; both_cnt = 0;
        bubbled = 1'b0;

        @(posedge clock);
        #1;
        bus.start   = 1'b1;
        bus.length  = LEN_W'(len);
        bus.bias_in = bias;
        @(posedge clock);
        #1;
        s_cyc     = cyc;
        bus.start = 1'b0;

        for (int i = 0; i < len; i++) begin
            b = (max_bub > 0) ? $urandom_range(0, max_bub) : 0;
            if (b > 0) bubbled = 1'b1;
            repeat (b) begin
                @(posedge clock);
                #1;
            end
            feed_pair(da[i], wa[i], ok);
            if (!ok) begin
                check("pair_accept_timeout", 32'(ok), 32'd1);
                void'(exp_q.pop_back());
                da.delete(); wa.delete();
                apply_reset();
                return;
            end
        end
        da.delete(); wa.delete();

        t = 0;
        do begin
            @(negedge clock);
            t++;
        end while (!bus.out_valid && t < 300);
        v_cyc = cyc;
        if (!bus.out_valid) begin
            check("out_valid_timeout", 32'(bus.out_valid), 32'd1);
            void'(exp_q.pop_back());
            apply_reset();
            return;
        end

        if (!bubbled) check("latency", 32'(v_cyc - s_cyc), 32'(len + 2));
        check("result", 32'(bus.out_result), 32'(exp_q.pop_front()));

        held = bus.out_result;
        stable_bad = 0;
        repeat (hold_cyc) begin
            @(posedge clock);
            #1;
            if (poke_start) begin
                bus.start   = 1'($urandom_range(0, 1));
                bus.length  = LEN_W'($urandom_range(0, 9));
                bus.bias_in = 8'($urandom);
            end
            @(negedge clock);
            if (!bus.out_valid || bus.out_result !== held || !bus.busy) stable_bad++;
        end
        bus.start = 1'b0;
        if (hold_cyc > 0) check("hold_stable_violations", 32'(stable_bad), 32'd0);

        @(posedge clock);
        #1;
        bus.out_ready = 1'b1;
        @(posedge clock);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clock);
        check("idle_after_accept", {30'd0, bus.busy, bus.out_valid}, 32'd0);

        check("enable_cycles", 32'(en_cnt), 32'(len));
        check("clear_pulses", 32'(clr_cnt), 32'd1);
        check("clear_enable_overlap", 32'(both_cnt), 32'd0);
        if (len == 0) check("in_ready_zero_len", 32'(rdy_cnt), 32'd0);
    endtask

    task automatic push_pair(input int d, input int w);
        da.push_back(8'(d));
        wa.push_back(8'(w));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int len;
        bus.start = 1'b0; bus.length = '0; bus.bias_in = '0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_weight = '0;
        bus.out_ready = 1'b0;

        repeat (2) @(posedge clock);
        @(negedge clock);
        check("reset_outputs",
              {bus.busy, bus.in_ready, bus.mac_clear, bus.mac_enable, bus.out_valid},
              32'd0);
        check("reset_result", 32'(bus.out_result), 32'd0);
        check("reset_bias", 32'(bus.mac_bias), 32'd0);
        #1;
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // Basic job, then the same job with bubbles.
        push_pair(2, 3); push_pair(-1, 4); push_pair(7, 7);
        run_job(3, 8'h05, 0, 0, 1'b0);
        push_pair(2, 3); push_pair(-1, 4); push_pair(7, 7);
        run_job(3, 8'h05, 3, 0, 1'b0);

        // Zero length returns sign-extended bias.
        run_job(0, 8'hFE, 0, 0, 1'b0);

        // Backpressure in HOLD with ignored start pulses.
        push_pair(-5, 9); push_pair(100, -2);
        run_job(2, 8'h80, 0, 10, 1'b1);

        // Wrap modulo 2^16.
        repeat (4) push_pair(127, 127);
        run_job(4, 8'h00, 0, 0, 1'b0);

        // Reset mid-ACCUM after 2 of 4 beats.
        @(posedge clock);
        #1;
        bus.start = 1'b1; bus.length = LEN_W'(4); bus.bias_in = 8'h11;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        feed_pair(8'd10, 8'd10, ok);
        feed_pair(8'd20, 8'd20, ok);
        reset_n = 1'b0;
        #1;
        check("async_reset_outputs",
              {bus.busy, bus.in_ready, bus.mac_clear, bus.mac_enable, bus.out_valid},
              32'd0);
        check("async_reset_result_bias", {bus.out_result, bus.mac_bias}, 32'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        push_pair(3, 3);
        run_job(1, 8'h00, 0, 0, 1'b0);

        // Randomized jobs.
        for (int j = 0; j < 8; j++) begin
            len = $urandom_range(0, 9);
            for (int i = 0; i < len; i++) push_pair($urandom_range(0, 255), $urandom_range(0, 255));
            run_job(len, 8'($urandom), (j % 2) * 2, $urandom_range(0, 3), 1'b0);
        end

        // Full-length job.
        for (int i = 0; i < MAX_LEN; i++) push_pair($urandom_range(0, 255), $urandom_range(0, 255));
        run_job(MAX_LEN, 8'($urandom), 0, 1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
